// File: rtl/fp_reduce_ctrl.sv
// fp_reduce_ctrl
//   Streaming max/min reduction over binary32 packets. Each packet arrives as
//   beats on a valid/ready stream. Every beat is folded into a running
//   extreme, and the packet produces one result beat.
//
//   Ports
//     clk, rst_n        single clock, asynchronous active-low reset
//     s_valid/s_ready   input stream handshake
//     s_data            binary32 operand
//     s_last            final beat of the packet
//     s_mode            0=max, 1=min; taken from the first beat only
//     m_valid/m_ready   result handshake
//     m_data            winning element (raw bits, unmodified)
//     m_count           number of elements folded into m_data
//     m_trunc           packet reached MAX_LEN without s_last
//     m_index           zero-based position of the winner
//                       (present only when FP_REDUCE_INDEX_EN is defined)
//
//   Optional feature macro: FP_REDUCE_INDEX_EN
module fp_reduce_ctrl #(
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  input  logic             s_mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [CNT_W-1:0] m_count,
`ifdef FP_REDUCE_INDEX_EN
  output logic [CNT_W-1:0] m_index,
`endif
  output logic             m_trunc
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;
  logic             take;
`ifdef FP_REDUCE_INDEX_EN
  logic [CNT_W-1:0] idx;
`endif

  // a > b under sign-magnitude total order on raw bits.
  // NaN and Inf are ordered by bit pattern alone.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return ~a[31];
    else if (!a[31])    return a[30:0] > b[30:0];
    else                return a[30:0] < b[30:0];
  endfunction

  assign beat    = s_valid && s_ready;
  assign cnt_inc = cnt + 1'b1;

  // The comparison is strict, so an identical value keeps the earlier element.
  always_comb begin
    take = 1'b0;
    if (mode_q) take = fp_gt(acc, s_data);
    else        take = fp_gt(s_data, acc);
  end

  // The accumulator and counter are already stable in DONE, so they drive
  // the result directly.
  assign m_data  = acc;
  assign m_count = cnt;
`ifdef FP_REDUCE_INDEX_EN
  assign m_index = idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_trunc <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
`ifdef FP_REDUCE_INDEX_EN
      idx     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // s_ready stays low through reset and rises on the first clock after.
          s_ready <= 1'b1;
          if (beat) begin
            acc     <= s_data;
            cnt     <= CNT_W'(1);
            mode_q  <= s_mode;
            m_trunc <= 1'b0;
`ifdef FP_REDUCE_INDEX_EN
            idx     <= '0;
`endif
            if (s_last) begin
              state   <= DONE;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
            end else begin
              state   <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            if (take) begin
              acc <= s_data;
`ifdef FP_REDUCE_INDEX_EN
              idx <= cnt;   // the new element sits at zero-based position cnt
`endif
            end
            cnt <= cnt_inc;
            if (s_last || cnt_inc == MAX_C) begin
              state   <= DONE;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_trunc <= ~s_last;
            end
          end
        end
        DONE: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
